// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
// Watches the one-hot phase vector of a ring counter. Classifies each enabled
// sample, tracks acquire/lock/fault state, and reports a binary phase index,
// a revolution counter and saturating error status. Every output is registered.
module ring_phase_monitor #(
  parameter int WIDTH    = 4,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = 3,
  parameter int REV_W    = 8,
  parameter int ERR_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         phase_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] idx_out,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     rev_tick,
  output logic [REV_W-1:0]         rev_count,
  output logic                     err_sticky,
  output logic [ERR_W-1:0]         err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
  logic [WIDTH-1:0]   r_prev, w_prev_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next, w_idx_enc;
  logic               r_idx_valid, w_idx_valid_next;
  logic               r_rev_tick, w_rev_tick_next;
  logic [REV_W-1:0]   r_rev_count, w_rev_count_next;
  logic               r_err_sticky, w_err_sticky_next;
  logic [ERR_W-1:0]   r_err_count, w_err_count_next, w_err_base;
  logic               w_err_evt;
  logic               w_onehot, w_step, w_stall, w_wrap;
  logic [WIDTH-1:0]   w_rot;

  // Sample classification: one-hot test, expected next phase and wrap target.
  assign w_onehot  = (phase_in != '0) && ((phase_in & (phase_in - 1'b1)) == '0);
  assign w_rot     = (DIR == 0) ? {r_prev[WIDTH-2:0], r_prev[WIDTH-1]}
                                : {r_prev[0], r_prev[WIDTH-1:1]};
  assign w_step    = w_onehot && (phase_in == w_rot);
  assign w_stall   = (phase_in == r_prev);
  assign w_wrap    = (DIR == 0) ? phase_in[0] : phase_in[WIDTH-1];
  assign w_cnt_inc = r_cnt + 1'b1;

  // Binary encoding of the set bit (only meaningful when one-hot).
  always_comb begin
    w_idx_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (phase_in[i]) w_idx_enc = IDX_W'(i);
    end
  end

  // Next-state and next-output logic for the lock tracker.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_prev_next       = r_prev;
    w_idx_next        = r_idx;
    w_idx_valid_next  = r_idx_valid;
    w_rev_tick_next   = 1'b0;
    w_rev_count_next  = r_rev_count;
    w_err_evt         = 1'b0;

    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (w_onehot) begin
            w_state_next = S_ACQUIRE;
            w_cnt_next   = '0;
            w_prev_next  = phase_in;
          end else begin
            w_err_evt = 1'b1;
          end
        end
        S_ACQUIRE: begin
          if (w_step) begin
            w_prev_next = phase_in;
            if (w_cnt_inc == CNT_W'(LOCK_CNT)) begin
              w_state_next = S_LOCKED;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end else if (w_stall) begin
            // Ring counter paused: keep waiting without penalty.
          end else if (w_onehot) begin
            // Legal phase but wrong position: resynchronise on it.
            w_err_evt   = 1'b1;
            w_cnt_next  = '0;
            w_prev_next = phase_in;
          end else begin
            w_err_evt    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        S_LOCKED: begin
          if (w_step) begin
            w_prev_next = phase_in;
            if (w_wrap) begin
              w_rev_tick_next  = 1'b1;
              w_rev_count_next = r_rev_count + 1'b1;
            end
          end else if (!w_stall) begin
            w_err_evt    = 1'b1;
            w_state_next = S_FAULT;
          end
        end
        default: begin
          // FAULT: samples are ignored until software clears the error.
        end
      endcase

      if (r_state != S_FAULT) begin
        w_idx_valid_next = w_onehot;
        if (w_onehot) w_idx_next = w_idx_enc;
      end
    end

    if (clr_err && (r_state == S_FAULT)) w_state_next = S_IDLE;

    // Clear first, then apply any same-cycle error event on top.
    w_err_base        = clr_err ? '0 : r_err_count;
    w_err_sticky_next = clr_err ? 1'b0 : r_err_sticky;
    w_err_count_next  = w_err_base;
    if (w_err_evt) begin
      w_err_sticky_next = 1'b1;
      if (w_err_base != '1) w_err_count_next = w_err_base + 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_idx        <= '0;
      r_idx_valid  <= 1'b0;
      r_rev_tick   <= 1'b0;
      r_rev_count  <= '0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_prev       <= w_prev_next;
      r_idx        <= w_idx_next;
      r_idx_valid  <= w_idx_valid_next;
      r_rev_tick   <= w_rev_tick_next;
      r_rev_count  <= w_rev_count_next;
      r_err_sticky <= w_err_sticky_next;
      r_err_count  <= w_err_count_next;
    end
  end

  assign idx_out    = r_idx;
  assign idx_valid  = r_idx_valid;
  assign locked     = (r_state == S_LOCKED);
  assign rev_tick   = r_rev_tick;
  assign rev_count  = r_rev_count;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Table-driven bench for ring_phase_monitor (WIDTH=4, DIR=0, LOCK_CNT=3).
// Each vector's expected outputs are queued when driven and compared one
// cycle later; async reset is checked by hand between clock edges.
module tb_ring_phase_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] phase_in = 4'b0000;
  logic [1:0] idx_out;
  logic       idx_valid, locked, rev_tick, err_sticky;
  logic [7:0] rev_count;
  logic [3:0] err_count;

  int checks = 0;
  int errors = 0;

  ring_phase_monitor #(.WIDTH(4), .DIR(0), .LOCK_CNT(3), .REV_W(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_in(phase_in), .clr_err(clr_err),
    .idx_out(idx_out), .idx_valid(idx_valid), .locked(locked),
    .rev_tick(rev_tick), .rev_count(rev_count),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] ph;
    logic       clr;
    logic [1:0] idx;
    logic       iv, lk, rt;
    logic [7:0] rc;
    logic       es;
    logic [3:0] ec;
  } vec_t;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  function automatic vec_t mk(logic e, logic [3:0] p, logic c, logic [1:0] i,
                              logic v, logic l, logic t, logic [7:0] r,
                              logic s, logic [3:0] n);
    vec_t x;
    x.en = e; x.ph = p; x.clr = c; x.idx = i; x.iv = v; x.lk = l;
    x.rt = t; x.rc = r; x.es = s; x.ec = n;
    return x;
  endfunction

  function automatic logic [17:0] outs();
    return {idx_out, idx_valid, locked, rev_tick, rev_count, err_sticky, err_count};
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic check_out();
    sb_t s;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%h required=<entry>", outs());
    end else begin
      s = sb_q.pop_front();
      if (outs() !== s.exp) begin
        errors++;
        $display("FAIL %s actual={idx,iv,lk,rt,rc,es,ec}=%h required=%h", s.name, outs(), s.exp);
      end else begin
        $display("ok   %s outputs=%h", s.name, outs());
      end
    end
  endtask

  task automatic apply(string name, vec_t v);
    sb_t s;
    en = v.en; phase_in = v.ph; clr_err = v.clr;
    s.name = name;
    s.exp  = {v.idx, v.iv, v.lk, v.rt, v.rc, v.es, v.ec};
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic run_range(string name, int lo, int hi);
    for (int i = lo; i <= hi; i++) apply($sformatf("%s[%0d]", name, i - lo), vecs[i]);
  endtask

  // Drop reset between edges, check outputs clear without a clock, release.
  task automatic async_reset(string name);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 18'h0) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, outs(), 18'h0);
    end else begin
      $display("ok   %s outputs=%h", name, outs());
    end
    en = 1'b0; clr_err = 1'b0; phase_in = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c_lo, c_hi, s_hi, w_lo, w_hi, a_lo, a_hi;

    // Clean run: acquire, lock after 1000, two revolutions.
    c_lo = vecs.size();
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 2, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 1, 2, 0, 0));
    c_hi = vecs.size() - 1;
    // Stall while locked, resume, en=0 hold, corruption, FAULT, clear, relock.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 2, 1, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 2, 1, 1, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 2, 0, 0, 0, 2, 1, 1));
    vecs.push_back(mk(1, 4'b0000, 0, 2, 0, 0, 0, 2, 1, 1));
    vecs.push_back(mk(1, 4'b0001, 0, 2, 0, 0, 0, 2, 1, 1));
    vecs.push_back(mk(1, 4'b0001, 1, 2, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4'b0010, 0, 1, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 2, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 2, 0, 0));
    s_hi = vecs.size() - 1;
    // Wrong step in ACQUIRE then resync and lock.
    w_lo = vecs.size();
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b1000, 0, 3, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 0, 0, 1, 1));
    w_hi = vecs.size() - 1;
    // Saturation from IDLE, then clear racing an error, then a clean clear.
    a_lo = vecs.size();
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 1, (i >= 14) ? 4'd15 : 4'(i + 1)));
    vecs.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b0001, 1, 0, 1, 0, 0, 0, 0, 0));
    a_hi = vecs.size() - 1;

    // Reset state.
    #2;
    checks++;
    if (outs() !== 18'h0) begin
      errors++;
      $display("FAIL reset_state actual=%h required=%h", outs(), 18'h0);
    end else begin
      $display("ok   reset_state outputs=%h", outs());
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_range("clean", c_lo, c_hi);
    run_range("stall_fault", c_hi + 1, s_hi);
    async_reset("async_reset_locked");
    run_range("clean_again", c_lo, c_hi);
    async_reset("async_reset_2");
    run_range("wrong_step", w_lo, w_hi);
    async_reset("async_reset_3");
    run_range("saturate", a_lo, a_hi);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
